// File: rtl/modular_exp_scaled.sv
// modular_exp_scaled: constant-time (scale * base^power) mod modulus over four valid/ready operand streams.
module modular_exp_scaled #(
  parameter int SIZE     = 64,
  parameter int EXP_SIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SIZE-1:0]     input_base_tdata,
  input  logic                input_base_tvalid,
  output logic                input_base_tready,
  input  logic [EXP_SIZE-1:0] input_power_tdata,
  input  logic                input_power_tvalid,
  output logic                input_power_tready,
  input  logic [SIZE-1:0]     input_modulus_tdata,
  input  logic                input_modulus_tvalid,
  output logic                input_modulus_tready,
  input  logic [SIZE-1:0]     input_scale_tdata,
  input  logic                input_scale_tvalid,
  output logic                input_scale_tready,
  output logic [SIZE-1:0]     output_tdata,
  output logic                output_error,
  output logic                output_tvalid,
  input  logic                output_tready
);
  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int EW = $clog2(EXP_SIZE + 1);
  typedef enum logic [1:0] {IDLE, REDUCE, EXP, DONE} state_t;
  state_t            state_q;
  logic [3:0]        flag_q, flag_d, rdy_q, hs;
  logic [SIZE-1:0]   base_q, mod_q, scale_q, acc_q, b_q, out_data_q;
  logic [EXP_SIZE-1:0] pow_q;
  logic [SIZE:0]     ra_q, rs_q, ra_d, rs_d, ba, bs, m;
  logic [BW-1:0]     bit_q;
  logic [EW-1:0]     it_q;
  logic              abit_a, abit_s, out_valid_q, out_err_q;
  // One interleaved shift-add step; r and m are one bit wider so 2r and r+b never overflow.
  function automatic logic [SIZE:0] mm_step(input logic [SIZE:0] r, input logic a,
                                            input logic [SIZE:0] b, input logic [SIZE:0] mo);
    logic [SIZE:0] t;
    t = {r[SIZE-1:0], 1'b0};
    t = (t >= mo) ? t - mo : t;
    t = a ? t + b : t;
    return (t >= mo) ? t - mo : t;
  endfunction
  assign {input_scale_tready, input_modulus_tready, input_power_tready, input_base_tready} = rdy_q;
  assign hs = rdy_q & {input_scale_tvalid, input_modulus_tvalid, input_power_tvalid, input_base_tvalid};
  assign flag_d = flag_q | hs;
  assign output_tdata = out_data_q;
  assign output_error = out_err_q;
  assign output_tvalid = out_valid_q;
  always_comb begin
    m      = {1'b0, mod_q};
    abit_a = (state_q == REDUCE) ? scale_q[bit_q] : acc_q[bit_q];
    abit_s = (state_q == REDUCE) ? base_q[bit_q] : b_q[bit_q];
    ba     = (state_q == REDUCE) ? (SIZE+1)'(1) : {1'b0, b_q};
    bs     = ba;
    ra_d   = mm_step(ra_q, abit_a, ba, m);
    rs_d   = mm_step(rs_q, abit_s, bs, m);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flag_q      <= '0;
      rdy_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs[0]) base_q  <= input_base_tdata;
          if (hs[1]) pow_q   <= input_power_tdata;
          if (hs[2]) mod_q   <= input_modulus_tdata;
          if (hs[3]) scale_q <= input_scale_tdata;
          flag_q <= flag_d;
          rdy_q  <= (&flag_d) ? 4'b0 : ~flag_d;
          if (&flag_d) begin
            state_q <= REDUCE;
            bit_q   <= BW'(SIZE - 1);
            ra_q    <= '0;
            rs_q    <= '0;
          end
        end
        REDUCE: begin
          if (mod_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b1;
            out_data_q  <= '0;
          end else begin
            ra_q  <= ra_d;
            rs_q  <= rs_d;
            bit_q <= bit_q - BW'(1);
            if (bit_q == '0) begin
              acc_q   <= ra_d[SIZE-1:0];
              b_q     <= rs_d[SIZE-1:0];
              ra_q    <= '0;
              rs_q    <= '0;
              bit_q   <= BW'(SIZE - 1);
              it_q    <= '0;
              state_q <= EXP;
            end
          end
        end
        EXP: begin
          ra_q  <= ra_d;
          rs_q  <= rs_d;
          bit_q <= bit_q - BW'(1);
          if (bit_q == '0) begin
            // The multiply always runs; only the commit into acc depends on the exponent bit.
            b_q   <= rs_d[SIZE-1:0];
            acc_q <= pow_q[0] ? ra_d[SIZE-1:0] : acc_q;
            pow_q <= pow_q >> 1;
            ra_q  <= '0;
            rs_q  <= '0;
            bit_q <= BW'(SIZE - 1);
            it_q  <= it_q + EW'(1);
            if (it_q == EW'(EXP_SIZE - 1)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b0;
              out_data_q  <= pow_q[0] ? ra_d[SIZE-1:0] : acc_q;
            end
          end
        end
        DONE: begin
          if (output_tready) begin
            state_q     <= IDLE;
            flag_q      <= '0;
            rdy_q       <= '1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/modular_exp_scaled.md
# modular_exp_scaled

Parametrised, constant-time modular exponentiation engine computing `output = (scale * base^power) mod modulus` over four independent valid/ready operand streams. It is the next-generation exponentiator for the ElGamal datapath. With `scale = 1` it produces `c1 = g^k mod p`. With `scale = m` it produces `c2 = m*y^k mod p` in a single pass. Operand width and exponent width are separate parameters. Runtime is data-independent, so exponent bits do not leak through latency.

## Interface
- `SIZE`, 64, width of base, scale, modulus and result
- `EXP_SIZE`, 64, width of the exponent, scanned LSB-first
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `input_base_tdata`  in  SIZE  base operand (may be ≥ modulus)
- `input_base_tvalid` / `input_base_tready`  in / out  1  base handshake
- `input_power_tdata`  in  EXP_SIZE  exponent
- `input_power_tvalid` / `input_power_tready`  in / out  1  exponent handshake
- `input_modulus_tdata`  in  SIZE  modulus
- `input_modulus_tvalid` / `input_modulus_tready`  in / out  1  modulus handshake
- `input_scale_tdata`  in  SIZE  multiplier (may be ≥ modulus)
- `input_scale_tvalid` / `input_scale_tready`  in / out  1  scale handshake
- `output_tdata`  out  SIZE  result
- `output_error`  out  1  qualified by `output_tvalid`; 1 when modulus was 0
- `output_tvalid` / `output_tready`  out / in  1  result handshake

## Operation
- **Reset.**
  - Any cycle with `rst` = 1 forces state IDLE and clears all capture flags.
  - The next cycle shows all outputs at 0: every tready, `output_tvalid`, `output_tdata` and `output_error`.
  - Asserting reset mid-operation aborts the operation with no output.
  - All readies rise in the first cycle after `rst` deasserts.
- **IDLE (operand capture).**
  - Each operand has its own capture flag.
  - Each `*_tready` is 1 while its flag is clear.
  - A handshake (`tvalid && tready`) registers the data, sets the flag and drops that ready the next cycle.
  - Operands arrive in any order, and any subset may arrive in the same cycle.
  - When all four flags are set, all readies are 0 and the engine leaves IDLE:
    - to DONE with `output_error` = 1 and `output_tdata` = 0 if modulus = 0;
    - otherwise to REDUCE.
- **Modular multiplier `mm(a,b)`.**
  - Interleaved shift-add over the SIZE bits of `a`, MSB first, one bit per cycle.
  - Each step: `r = 2r; if r ≥ m then r -= m; if a[i] then r += b; if r ≥ m then r -= m`.
  - Requires `b < m`.
  - The `r` register and comparators are SIZE+1 bits wide to hold `2r` and `r+b` without overflow.
  - Two identical units, MA and MS, run in lock-step.
- **REDUCE** (SIZE cycles):
  - MA computes `acc = mm(scale, 1)` and MS computes `b = mm(base, 1)`.
  - Modulus = 1 yields 0 through this normal path, with no error.
- **EXP** (EXP_SIZE iterations of SIZE cycles each), for bit i = 0..EXP_SIZE-1:
  - MA computes `mm(acc, b)` and MS computes `mm(b, b)`, both from the pre-iteration `b`.
  - At iteration end, `b` is always updated.
  - `acc` is updated only if `power[i]` = 1; the multiply is always executed (constant time).
- **DONE.**
  - Drive `output_tdata` = `acc`, `output_error` = 0 (or the error values above) and `output_tvalid` = 1.
  - Hold all output values stable until `output_tready` = 1.
  - On that handshake cycle, return to IDLE with flags cleared; readies rise the next cycle.

## Timing
- **Latency.** Let T be the cycle of the last operand handshake.
  - Normal path: `output_tvalid` = 1 at cycle T+1+(EXP_SIZE+1)·SIZE, independent of data.
  - Modulus = 0: `output_tvalid` = 1 at cycle T+2.
- **Throughput.** One result per operation. No new operand is accepted between the last capture and the output handshake.
- **Back-pressure.** `output_tready` may be held low indefinitely; outputs stay frozen.
- **Output handshake.** If `output_tready` is already 1 when valid rises, the handshake completes in that same cycle.
- **Input side.** `tvalid` deasserted after a capture has no effect. Data offered on a captured operand is ignored; its ready is low.
- **Simultaneity.** Reset wins over every other event in the same cycle, including an output handshake.

## Test plan
- SIZE=8, EXP_SIZE=8. Send base=3, power=5, modulus=7, scale=1, all in one cycle T -> `output_tdata`=5, `output_error`=0, `output_tvalid` first high at T+73.
- Repeat with scale=4 -> 6. Then base=2, power=10, modulus=11, scale=1 -> 1.
- Operands that need reduction: base=200, power=3, modulus=13, scale=1 -> 8. Power=0, scale=9, modulus=7 -> 2. Modulus=1 -> 0 with error=0.
- Modulus=0 with any other operands -> `output_tdata`=0, `output_error`=1, valid at T+2.
- Operand order: stagger the operands over 10 cycles in the order scale, power, base, modulus, with a duplicate base offered after capture.
  - Each ready falls exactly one cycle after its own handshake.
  - The duplicate base is ignored.
  - Latency is measured from the modulus handshake.
- Back-pressure and reset:
  - Hold `output_tready` low for 50 cycles -> data and valid stay stable.
  - Then pulse ready for one cycle -> readies return the next cycle.
  - Assert `rst` mid-EXP -> all outputs 0, no result emitted, and a new operation then computes correctly.
